// File: rtl/tmr_ctrl_pkg.sv
// Shared types and helpers for the TMR fault supervisor.
package tmr_ctrl_pkg;

    localparam int NUM_REPLICAS = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MONITOR  = 3'd1,
        ST_RESYNC   = 3'd2,
        ST_DEGRADED = 3'd3,
        ST_ALARM    = 3'd4
    } state_t;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/tmr_err_tracker.sv
// Per-replica error bookkeeping: saturating total count, consecutive-fault
// run length and the health flag that drops when the run reaches ERR_THRESH.
module tmr_err_tracker #(
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clean,
    input  logic             clear,
    output logic [CNT_W-1:0] err_cnt,
    output logic             ok,
    output logic             hit
);

    localparam int CW = $clog2(ERR_THRESH + 1);
    localparam logic [CW-1:0] LAST = CW'(ERR_THRESH - 1);

    logic [CW-1:0] consec;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next fault on this replica would complete the retirement run.
    assign hit = ok && (consec == LAST);

    // clean overrides inc on the run length: used where an error is counted
    // but must not advance toward retirement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt <= '0;
            consec  <= '0;
            ok      <= 1'b1;
        end else if (clear) begin
            err_cnt <= '0;
            consec  <= '0;
            ok      <= 1'b1;
        end else if (ok) begin
            if (inc)
                err_cnt <= sat_inc(err_cnt);
            if (clean)
                consec <= '0;
            else if (inc) begin
                consec <= consec + 1'b1;
                if (hit)
                    ok <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tmr_fault_manager.sv
// Supervisory FSM for the triple-redundant datapath: resync sequencing,
// replica retirement and the sticky voting-unreliable alarm.
module tmr_fault_manager
    import tmr_ctrl_pkg::*;
#(
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable_i,
    input  logic                           clear_i,
    input  logic [NUM_REPLICAS-1:0]        fault_i,
    output logic [NUM_REPLICAS-1:0]        resync_o,
    output logic [NUM_REPLICAS-1:0]        replica_ok_o,
    output logic [NUM_REPLICAS*CNT_W-1:0]  err_cnt_o,
    output logic [2:0]                     state_o,
    output logic                           degraded_o,
    output logic                           alarm_o
);

    state_t                  state;
    logic [NUM_REPLICAS-1:0] ok;
    logic [NUM_REPLICAS-1:0] hit;
    logic [NUM_REPLICAS-1:0] flt;
    logic [NUM_REPLICAS-1:0] inc;
    logic [NUM_REPLICAS-1:0] clean;
    logic [1:0]              nflt;

    assign flt = fault_i & ok;

    // Only a lone fault in MONITOR advances the run length; every other
    // counted error (multi-fault, degraded) resets it so no retirement occurs.
    always_comb begin
        inc   = '0;
        clean = '0;
        nflt  = popcount3(flt);
        case (state)
            ST_MONITOR: begin
                inc = flt;
                if (nflt != 2'd1)
                    clean = '1;
            end
            ST_DEGRADED: begin
                inc   = flt;
                clean = '1;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < NUM_REPLICAS; k++) begin : g_trk
        tmr_err_tracker #(
            .ERR_THRESH(ERR_THRESH),
            .CNT_W     (CNT_W)
        ) u_trk (
            .clk    (clk),
            .rst    (rst),
            .inc    (inc[k]),
            .clean  (clean[k]),
            .clear  (clear_i),
            .err_cnt(err_cnt_o[k*CNT_W +: CNT_W]),
            .ok     (ok[k]),
            .hit    (hit[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            resync_o   <= '0;
            degraded_o <= 1'b0;
            alarm_o    <= 1'b0;
        end else if (clear_i) begin
            state      <= ST_IDLE;
            resync_o   <= '0;
            degraded_o <= 1'b0;
            alarm_o    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:
                    if (enable_i)
                        state <= ST_MONITOR;
                ST_MONITOR: begin
                    if (nflt >= 2'd2) begin
                        state   <= ST_ALARM;
                        alarm_o <= 1'b1;
                    end else if (nflt == 2'd1) begin
                        if (|(flt & hit)) begin
                            state      <= ST_DEGRADED;
                            degraded_o <= 1'b1;
                        end else begin
                            state    <= ST_RESYNC;
                            resync_o <= flt;
                        end
                    end else if (!enable_i)
                        state <= ST_IDLE;
                end
                ST_RESYNC: begin
                    resync_o <= '0;
                    state    <= ST_MONITOR;
                end
                // Two survivors cannot outvote each other: any fault is fatal.
                ST_DEGRADED:
                    if (|flt) begin
                        state   <= ST_ALARM;
                        alarm_o <= 1'b1;
                    end
                ST_ALARM: ;
                default:
                    state <= ST_IDLE;
            endcase
        end
    end

    assign state_o      = state;
    assign replica_ok_o = ok;

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Directed bench for tmr_fault_manager: one default-sized instance and one
// with 2-bit counters for saturation and reset-during-resync.
module tb_tmr_fault_manager;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, clr_a;
    logic [2:0]  flt_a, rsy_a, ok_a, st_a;
    logic [23:0] cnt_a;
    logic        deg_a, alm_a;

    logic        rst_b, en_b, clr_b;
    logic [2:0]  flt_b, rsy_b, ok_b, st_b;
    logic [5:0]  cnt_b;
    logic        deg_b, alm_b;

    int n_checks = 0;
    int n_errors = 0;

    tmr_fault_manager #(.ERR_THRESH(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst(rst_a), .enable_i(en_a), .clear_i(clr_a),
        .fault_i(flt_a), .resync_o(rsy_a), .replica_ok_o(ok_a),
        .err_cnt_o(cnt_a), .state_o(st_a), .degraded_o(deg_a), .alarm_o(alm_a)
    );

    tmr_fault_manager #(.ERR_THRESH(4), .CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst_b), .enable_i(en_b), .clear_i(clr_b),
        .fault_i(flt_b), .resync_o(rsy_b), .replica_ok_o(ok_b),
        .err_cnt_o(cnt_b), .state_o(st_b), .degraded_o(deg_b), .alarm_o(alm_b)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, ".state"}, 32'(st_a), 32'd0);
        check({tag, ".resync"}, 32'(rsy_a), 32'd0);
        check({tag, ".ok"}, 32'(ok_a), 32'b111);
        check({tag, ".cnt"}, 32'(cnt_a), 32'd0);
        check({tag, ".deg"}, 32'(deg_a), 32'd0);
        check({tag, ".alarm"}, 32'(alm_a), 32'd0);
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0; clr_a = 1'b0; flt_a = 3'b000;
        rst_b = 1'b0; en_b = 1'b0; clr_b = 1'b0; flt_b = 3'b000;
        tick();
        tick();
        check_idle_a("reset");
        rst_a = 1'b1;

        // Enable and run clean for 20 cycles
        en_a = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("mon.state", 32'(st_a), 32'd1);
        check("mon.resync", 32'(rsy_a), 32'd0);
        check("mon.cnt", 32'(cnt_a), 32'd0);

        // Single fault on replica 1
        flt_a = 3'b010;
        tick();
        flt_a = 3'b000;
        check("f1.resync", 32'(rsy_a), 32'b010);
        check("f1.state", 32'(st_a), 32'd2);
        check("f1.cnt1", 32'(cnt_a[15:8]), 32'd1);
        tick();
        check("f1.resync_off", 32'(rsy_a), 32'd0);
        check("f1.back", 32'(st_a), 32'd1);
        tick();
        tick();

        // Persistent fault on replica 0 until retirement
        flt_a = 3'b001;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("p%0d.resync", i), 32'(rsy_a), 32'b001);
            check($sformatf("p%0d.cnt0", i), 32'(cnt_a[7:0]), 32'(i));
            tick();
            check($sformatf("p%0d.resync_off", i), 32'(rsy_a), 32'd0);
            check($sformatf("p%0d.state", i), 32'(st_a), 32'd1);
        end
        tick();
        check("ret.state", 32'(st_a), 32'd3);
        check("ret.ok", 32'(ok_a), 32'b110);
        check("ret.deg", 32'(deg_a), 32'd1);
        check("ret.cnt0", 32'(cnt_a[7:0]), 32'd4);
        check("ret.resync", 32'(rsy_a), 32'd0);
        check("ret.cnt1", 32'(cnt_a[15:8]), 32'd1);
        tick();
        check("ret.ign_state", 32'(st_a), 32'd3);
        check("ret.ign_cnt0", 32'(cnt_a[7:0]), 32'd4);

        // Fault on a survivor while degraded
        flt_a = 3'b100;
        tick();
        flt_a = 3'b000;
        check("dg.state", 32'(st_a), 32'd4);
        check("dg.alarm", 32'(alm_a), 32'd1);
        check("dg.cnt2", 32'(cnt_a[23:16]), 32'd1);
        check("dg.ok", 32'(ok_a), 32'b110);
        en_a = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("al.sticky_state", 32'(st_a), 32'd4);
        check("al.sticky_alarm", 32'(alm_a), 32'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check_idle_a("clr1");

        // Double fault in MONITOR
        en_a = 1'b1;
        tick();
        check("dbl.mon", 32'(st_a), 32'd1);
        flt_a = 3'b011;
        tick();
        flt_a = 3'b000;
        check("dbl.state", 32'(st_a), 32'd4);
        check("dbl.alarm", 32'(alm_a), 32'd1);
        check("dbl.cnt0", 32'(cnt_a[7:0]), 32'd1);
        check("dbl.cnt1", 32'(cnt_a[15:8]), 32'd1);
        check("dbl.resync", 32'(rsy_a), 32'd0);
        check("dbl.ok", 32'(ok_a), 32'b111);
        clr_a = 1'b1;
        en_a  = 1'b0;
        tick();
        clr_a = 1'b0;
        check_idle_a("clr2");

        // Enable drop in MONITOR returns to IDLE
        en_a = 1'b1;
        tick();
        en_a = 1'b0;
        tick();
        check("dis.state", 32'(st_a), 32'd0);

        // Saturating counter instance
        rst_b = 1'b1;
        en_b  = 1'b1;
        tick();
        check("b.mon", 32'(st_b), 32'd1);
        for (int i = 0; i < 5; i++) begin
            flt_b = 3'b100;
            tick();
            flt_b = 3'b000;
            check($sformatf("b.f%0d.resync", i), 32'(rsy_b), 32'b100);
            tick();
            tick();
        end
        check("b.sat_cnt2", 32'(cnt_b[5:4]), 32'd3);
        check("b.ok", 32'(ok_b), 32'b111);
        check("b.deg", 32'(deg_b), 32'd0);

        // Reset asserted while resync pulse is high
        flt_b = 3'b100;
        tick();
        flt_b = 3'b000;
        check("b.rs.resync_hi", 32'(rsy_b), 32'b100);
        #2;
        rst_b = 1'b0;
        #1;
        check("b.rs.resync_drop", 32'(rsy_b), 32'd0);
        check("b.rs.state", 32'(st_b), 32'd0);
        check("b.rs.cnt", 32'(cnt_b), 32'd0);
        rst_b = 1'b1;
        tick();
        check("b.rs.no_reissue1", 32'(rsy_b), 32'd0);
        tick();
        check("b.rs.no_reissue2", 32'(rsy_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tmr_fault_manager.md
# tmr_fault_manager

Supervisory controller for the triple-redundant counter datapath. It samples the per-replica mismatch flags produced against the voted value and counts errors per replica. It sequences one-cycle resynchronization pulses that force a faulty replica to reload from the voted value. It retires replicas that fault persistently and raises a sticky alarm when majority voting can no longer be trusted. It sits beside the voter at the top level and drives the replicas' resync inputs.

## Interface
- `ERR_THRESH`, 4: consecutive fault events on one replica before it is retired (range 1..15).
- `CNT_W`, 8: width of each saturating per-replica error counter.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset, asynchronous and active-low.
- `enable_i`  input  1  monitoring enable.
- `clear_i`  input  1  synchronous clear of counters, health mask and alarm.
- `fault_i`  input  3  per-replica mismatch flags; bit k=1 means replica k differs from the voted value.
- `resync_o`  output  3  one-hot, one-cycle pulse; replica k must load the voted value.
- `replica_ok_o`  output  3  health mask; 0 = retired.
- `err_cnt_o`  output  3*CNT_W  saturating total error counts; replica k in bits [k*CNT_W +: CNT_W].
- `state_o`  output  3  current FSM state encoding.
- `degraded_o`  output  1  exactly one replica retired.
- `alarm_o`  output  1  sticky; voting unreliable.

## Operation
- States: IDLE=0, MONITOR=1, RESYNC=2, DEGRADED=3, ALARM=4.
- IDLE: `enable_i`=1 -> MONITOR.
- MONITOR: let F = `fault_i` & `replica_ok_o`.
  - popcount(F)>=2 -> ALARM.
  - popcount(F)=1 on replica k: increment err_cnt[k] (saturate at 2^CNT_W-1) and consec[k].
    - If consec[k] reaches ERR_THRESH: clear ok[k] and go to DEGRADED.
    - Otherwise latch k and go to RESYNC.
  - F=0: clear consec for every healthy replica and stay.
  - `enable_i`=0 -> IDLE, evaluated after the fault checks.
- RESYNC: `resync_o` = one-hot(k) for exactly this cycle, then MONITOR. `fault_i` is ignored in this cycle, and `enable_i` is not sampled.
- DEGRADED: any fault on a remaining healthy replica increments its err_cnt, then -> ALARM. No resync is issued, because 2-of-2 cannot arbitrate. `enable_i`=0 leaves the state unchanged.
- ALARM: terminal. Only `clear_i` or reset exits it.
- Faults on retired replicas are ignored and not counted.
- `clear_i`: highest priority, from any state. Next cycle: counters and consec = 0, ok = 3'b111, alarm=0, state IDLE.
- consec counters: width clog2(ERR_THRESH+1). They are not externally visible.

## Timing
- Reset values:
  - state IDLE
  - `resync_o`=0, `err_cnt_o`=0, `replica_ok_o`=3'b111
  - `degraded_o`=0, `alarm_o`=0
  - all consec=0
- All outputs are registered; no combinational path from input to output.
- Fault sampled in MONITOR at edge N -> `resync_o` high during cycle N+1 -> back to MONITOR at edge N+2. The replica reload completes at edge N+2.
- Retirement: `replica_ok_o[k]` falls and `degraded_o` rises in the cycle after the ERR_THRESH-th event.
- `alarm_o` rises one cycle after the qualifying sample.
- Reset asserted mid-RESYNC: `resync_o` drops immediately (asynchronous) and the pulse is not re-issued.

## Structure
- Package `tmr_ctrl_pkg`:
  - `NUM_REPLICAS`=3
  - `state_t` enum with the encodings above
  - one popcount function for 3-bit vectors
- Sub-module `tmr_err_tracker`, instantiated once per replica. It holds the saturating err_cnt, the consec counter and the ok flag. Inputs: inc, clean, clear. Output: the threshold-hit flag.
- Top level holds the FSM, the latched replica index and the output registers.

## Test plan
- Reset then `enable_i`=1, `fault_i`=0 for 20 cycles -> state MONITOR, `resync_o`=0, all counts 0.
- `fault_i`=3'b010 for one cycle -> `resync_o`=3'b010 exactly one cycle later, `err_cnt_o[1]`=1, then return to MONITOR.
- ERR_THRESH=4, `fault_i`=3'b001 re-asserted each MONITOR cycle, no clean cycle in between -> three resync pulses, then `replica_ok_o`=3'b110, `degraded_o`=1, `err_cnt_o[0]`=4.
- From DEGRADED (replica 0 retired), `fault_i`=3'b100 -> `alarm_o`=1, state ALARM. Later `fault_i`=0 leaves ALARM in place until `clear_i`.
- In MONITOR, `fault_i`=3'b011 -> ALARM next cycle, both counters =1, no `resync_o`. Then `clear_i` pulse -> IDLE with every output at its reset value.
- CNT_W=2, 5 isolated single faults on replica 2 with clean cycles between them -> `err_cnt_o[2]` saturates at 3 and replica 2 stays healthy. Reset asserted during a RESYNC cycle -> `resync_o` low the same cycle.
